// File: rtl/bus_arbiter.sv
// Two-master to one-slave bus arbiter. Supports round-robin or fixed-priority
// grant, combinational pass-through while granted, and an optional timeout abort.
module bus_arbiter #(
  parameter int FAIR    = 1,
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_address_in,
  input  logic [31:0] m1_address_in,
  input  logic        m0_sel_in,
  input  logic        m1_sel_in,
  input  logic [3:0]  m0_write_mask_in,
  input  logic [3:0]  m1_write_mask_in,
  input  logic [31:0] m0_write_value_in,
  input  logic [31:0] m1_write_value_in,
  output logic [31:0] m0_read_value_out,
  output logic [31:0] m1_read_value_out,
  output logic        m0_ready_out,
  output logic        m1_ready_out,
  output logic [31:0] address_out,
  output logic        sel_out,
  output logic [3:0]  write_mask_out,
  output logic [31:0] write_value_out,
  input  logic [31:0] read_value_in,
  input  logic        ready_in,
  output logic        timeout_out
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t        state, next_state;
  logic          last_grant;   // 1 = m1 was granted most recently
  logic [CW-1:0] cnt;
  logic          gsel, granted, drop, done, abort, fire;

  always_comb begin
    gsel = 1'b0;
    case (state)
      GRANT0:  gsel = m0_sel_in;
      GRANT1:  gsel = m1_sel_in;
      default: gsel = 1'b0;
    endcase
    granted = (state != IDLE);
    drop    = granted && !gsel;
    done    = granted && gsel && ready_in;
    abort   = (TIMEOUT != 0) && granted && gsel && !ready_in && (cnt == TO_LAST);
    // Completion pulses are suppressed while reset is held so an abandoned
    // transaction never reports ready.
    fire    = (done || abort) && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      state <= next_state;
      if (state == IDLE && next_state != IDLE) begin
        last_grant <= (next_state == GRANT1);
        cnt        <= '0;
      end else if (granted && !ready_in && cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (m0_sel_in && m1_sel_in)
          next_state = (FAIR != 0 && !last_grant) ? GRANT1 : GRANT0;
        else if (m0_sel_in)
          next_state = GRANT0;
        else if (m1_sel_in)
          next_state = GRANT1;
      end
      GRANT0, GRANT1: begin
        if (drop || done || abort) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    sel_out           = 1'b0;
    address_out       = '0;
    write_mask_out    = '0;
    write_value_out   = '0;
    m0_ready_out      = 1'b0;
    m1_ready_out      = 1'b0;
    m0_read_value_out = '0;
    m1_read_value_out = '0;
    timeout_out       = abort && !reset;
    case (state)
      GRANT0: begin
        sel_out         = 1'b1;
        address_out     = m0_address_in;
        write_mask_out  = m0_write_mask_in;
        write_value_out = m0_write_value_in;
        m0_ready_out    = fire;
        if (done && !reset) m0_read_value_out = read_value_in;
      end
      GRANT1: begin
        sel_out         = 1'b1;
        address_out     = m1_address_in;
        write_mask_out  = m1_write_mask_in;
        write_value_out = m1_write_value_in;
        m1_ready_out    = fire;
        if (done && !reset) m1_read_value_out = read_value_in;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: per-cycle vector table on a FAIR=1/TIMEOUT=4
// instance plus a hand sequence for the fixed-priority instance.
module tb_bus_arbiter;

  localparam logic [31:0] A0 = 32'h0000_0010;
  localparam logic [31:0] A1 = 32'h0000_0020;
  localparam logic [31:0] W0 = 32'h1111_1111;
  localparam logic [31:0] W1 = 32'h0000_ABCD;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] m0_address_in, m1_address_in, m0_write_value_in, m1_write_value_in;
  logic        m0_sel_in, m1_sel_in, ready_in;
  logic [3:0]  m0_write_mask_in, m1_write_mask_in;
  logic [31:0] read_value_in;

  logic [31:0] a_v0, a_v1, a_addr, a_wv, b_v0, b_v1, b_addr, b_wv;
  logic        a_r0, a_r1, a_sel, a_to, b_r0, b_r1, b_sel, b_to;
  logic [3:0]  a_wm, b_wm;

  always #5 clk = ~clk;

  bus_arbiter #(.FAIR(1), .TIMEOUT(4)) dut_a (
    .clk(clk), .reset(reset),
    .m0_address_in(m0_address_in), .m1_address_in(m1_address_in),
    .m0_sel_in(m0_sel_in), .m1_sel_in(m1_sel_in),
    .m0_write_mask_in(m0_write_mask_in), .m1_write_mask_in(m1_write_mask_in),
    .m0_write_value_in(m0_write_value_in), .m1_write_value_in(m1_write_value_in),
    .m0_read_value_out(a_v0), .m1_read_value_out(a_v1),
    .m0_ready_out(a_r0), .m1_ready_out(a_r1),
    .address_out(a_addr), .sel_out(a_sel), .write_mask_out(a_wm), .write_value_out(a_wv),
    .read_value_in(read_value_in), .ready_in(ready_in), .timeout_out(a_to));

  bus_arbiter #(.FAIR(0), .TIMEOUT(16)) dut_b (
    .clk(clk), .reset(reset),
    .m0_address_in(m0_address_in), .m1_address_in(m1_address_in),
    .m0_sel_in(m0_sel_in), .m1_sel_in(m1_sel_in),
    .m0_write_mask_in(m0_write_mask_in), .m1_write_mask_in(m1_write_mask_in),
    .m0_write_value_in(m0_write_value_in), .m1_write_value_in(m1_write_value_in),
    .m0_read_value_out(b_v0), .m1_read_value_out(b_v1),
    .m0_ready_out(b_r0), .m1_ready_out(b_r1),
    .address_out(b_addr), .sel_out(b_sel), .write_mask_out(b_wm), .write_value_out(b_wv),
    .read_value_in(read_value_in), .ready_in(ready_in), .timeout_out(b_to));

  // g: expected grant seen on the bus this cycle (0 none, 1 m0, 2 m1)
  typedef struct {
    logic rst, s0, s1; logic [3:0] wm1; logic rdy; logic [31:0] rd;
    int g; logic r0, r1; logic [31:0] v0, v1; logic to;
  } vec_t;

  vec_t vecs[$];
  int checks = 0, failures = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t v(logic rst, logic s0, logic s1, logic [3:0] wm1, logic rdy,
                             logic [31:0] rd, int g, logic r0, logic r1,
                             logic [31:0] v0, logic [31:0] v1, logic to);
    vec_t x;
    x.rst = rst; x.s0 = s0; x.s1 = s1; x.wm1 = wm1; x.rdy = rdy; x.rd = rd;
    x.g = g; x.r0 = r0; x.r1 = r1; x.v0 = v0; x.v1 = v1; x.to = to;
    return x;
  endfunction

  initial begin
    // idle after reset
    vecs.push_back(v(0,0,0,0,0,0,            0,0,0,0,0,0));
    // single read by m0
    vecs.push_back(v(0,1,0,0,0,0,            0,0,0,0,0,0));
    vecs.push_back(v(0,1,0,0,0,0,            1,0,0,0,0,0));
    vecs.push_back(v(0,1,0,0,1,32'hDEADBEEF, 1,1,0,32'hDEADBEEF,0,0));
    vecs.push_back(v(0,0,0,0,0,32'hDEADBEEF, 0,0,0,0,0,0));
    // m1 write, mask 0011
    vecs.push_back(v(0,0,1,4'b0011,0,0,      0,0,0,0,0,0));
    vecs.push_back(v(0,0,1,4'b0011,0,0,      2,0,0,0,0,0));
    vecs.push_back(v(0,0,1,4'b0011,1,32'h5555, 2,0,1,0,32'h5555,0));
    vecs.push_back(v(0,0,0,4'b0011,0,0,      0,0,0,0,0,0));
    // continuous tie, round robin, memory ready immediately
    vecs.push_back(v(0,1,1,0,1,32'hA0A0A0A0, 0,0,0,0,0,0));
    vecs.push_back(v(0,1,1,0,1,32'hA0A0A0A0, 1,1,0,32'hA0A0A0A0,0,0));
    vecs.push_back(v(0,1,1,0,1,32'hA0A0A0A0, 0,0,0,0,0,0));
    vecs.push_back(v(0,1,1,0,1,32'hA0A0A0A0, 2,0,1,0,32'hA0A0A0A0,0));
    vecs.push_back(v(0,1,1,0,1,32'hA0A0A0A0, 0,0,0,0,0,0));
    vecs.push_back(v(0,1,1,0,1,32'hA0A0A0A0, 1,1,0,32'hA0A0A0A0,0,0));
    vecs.push_back(v(0,1,1,0,1,32'hA0A0A0A0, 0,0,0,0,0,0));
    vecs.push_back(v(0,1,1,0,1,32'hA0A0A0A0, 2,0,1,0,32'hA0A0A0A0,0));
    vecs.push_back(v(0,0,0,0,0,0,            0,0,0,0,0,0));
    // timeout after 4 granted cycles without ready
    vecs.push_back(v(0,1,0,0,0,0,            0,0,0,0,0,0));
    vecs.push_back(v(0,1,0,0,0,32'h12345678, 1,0,0,0,0,0));
    vecs.push_back(v(0,1,0,0,0,32'h12345678, 1,0,0,0,0,0));
    vecs.push_back(v(0,1,0,0,0,32'h12345678, 1,0,0,0,0,0));
    vecs.push_back(v(0,1,0,0,0,32'h12345678, 1,1,0,0,0,1));
    vecs.push_back(v(0,0,0,0,0,0,            0,0,0,0,0,0));
    // granted master drops sel: no ready, then idle
    vecs.push_back(v(0,0,1,0,0,0,            0,0,0,0,0,0));
    vecs.push_back(v(0,0,1,0,0,0,            2,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,1,32'h99,       2,0,0,0,0,0));
    vecs.push_back(v(0,0,0,0,0,0,            0,0,0,0,0,0));
    // m1 arrives while m0 is granted and waits for idle
    vecs.push_back(v(0,1,0,0,0,0,            0,0,0,0,0,0));
    vecs.push_back(v(0,1,1,0,0,0,            1,0,0,0,0,0));
    vecs.push_back(v(0,1,1,0,1,32'hCAFE,     1,1,0,32'hCAFE,0,0));
    vecs.push_back(v(0,0,1,0,0,0,            0,0,0,0,0,0));
    vecs.push_back(v(0,0,1,0,1,32'hBEEF,     2,0,1,0,32'hBEEF,0));
    vecs.push_back(v(0,0,0,0,0,0,            0,0,0,0,0,0));
    // reset while m0 granted: abandoned, next tie back to m0
    vecs.push_back(v(0,1,0,0,0,0,            0,0,0,0,0,0));
    vecs.push_back(v(0,1,0,0,0,0,            1,0,0,0,0,0));
    vecs.push_back(v(1,1,1,0,0,0,            1,0,0,0,0,0));
    vecs.push_back(v(0,1,1,0,1,32'h42,       0,0,0,0,0,0));
    vecs.push_back(v(0,1,1,0,1,32'h42,       1,1,0,32'h42,0,0));
    vecs.push_back(v(0,0,0,0,0,0,            0,0,0,0,0,0));
  end

  initial begin
    reset = 1'b1;
    m0_address_in = A0; m1_address_in = A1;
    m0_write_value_in = W0; m1_write_value_in = W1;
    m0_write_mask_in = 4'b0000; m1_write_mask_in = 4'b0000;
    m0_sel_in = 1'b0; m1_sel_in = 1'b0; ready_in = 1'b0; read_value_in = '0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      logic [31:0] eaddr, ewv; logic [3:0] ewm; logic esel;
      @(negedge clk);
      reset = vecs[i].rst; m0_sel_in = vecs[i].s0; m1_sel_in = vecs[i].s1;
      m1_write_mask_in = vecs[i].wm1; ready_in = vecs[i].rdy; read_value_in = vecs[i].rd;
      esel = (vecs[i].g != 0);
      eaddr = (vecs[i].g == 1) ? A0 : (vecs[i].g == 2) ? A1 : 32'h0;
      ewv   = (vecs[i].g == 1) ? W0 : (vecs[i].g == 2) ? W1 : 32'h0;
      ewm   = (vecs[i].g == 2) ? vecs[i].wm1 : 4'h0;
      #2;
      check($sformatf("row%0d.sel", i),   {31'b0, a_sel}, {31'b0, esel});
      check($sformatf("row%0d.addr", i),  a_addr, eaddr);
      check($sformatf("row%0d.wmask", i), {28'b0, a_wm}, {28'b0, ewm});
      check($sformatf("row%0d.wval", i),  a_wv, ewv);
      check($sformatf("row%0d.m0rdy", i), {31'b0, a_r0}, {31'b0, vecs[i].r0});
      check($sformatf("row%0d.m1rdy", i), {31'b0, a_r1}, {31'b0, vecs[i].r1});
      check($sformatf("row%0d.m0rv", i),  a_v0, vecs[i].v0);
      check($sformatf("row%0d.m1rv", i),  a_v1, vecs[i].v1);
      check($sformatf("row%0d.tmo", i),   {31'b0, a_to}, {31'b0, vecs[i].to});
    end

    // Tie from reset: fixed priority always m0, round robin alternates.
    @(negedge clk);
    reset = 1'b1; m0_sel_in = 1'b0; m1_sel_in = 1'b0; ready_in = 1'b0;
    m1_write_mask_in = 4'b0000;
    @(negedge clk);
    reset = 1'b0; m0_sel_in = 1'b1; m1_sel_in = 1'b1; ready_in = 1'b1;
    read_value_in = 32'h5A5A5A5A;
    for (int i = 0; i < 8; i++) begin
      #2;
      check($sformatf("fix%0d.m0rdy", i), {31'b0, b_r0}, {31'b0, (i % 2 == 1)});
      check($sformatf("fix%0d.m1rdy", i), {31'b0, b_r1}, 32'h0);
      check($sformatf("fix%0d.m1rv", i),  b_v1, 32'h0);
      check($sformatf("rr%0d.m0rdy", i),  {31'b0, a_r0}, {31'b0, (i % 4 == 1)});
      check($sformatf("rr%0d.m1rdy", i),  {31'b0, a_r1}, {31'b0, (i % 4 == 3)});
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter FAIR, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority with m0 winning.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, meaning the maximum number of granted cycles without ready_in before an abort; 0 disables the timeout.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 m0_address_in, m1_address_in  input  32 each  master byte addresses.
REQ-006 m0_sel_in, m1_sel_in  input  1 each  master requests; a master holds its request until its ready is seen.
REQ-007 m0_write_mask_in, m1_write_mask_in  input  4 each  byte write strobes; 0 means read.
REQ-008 m0_write_value_in, m1_write_value_in  input  32 each  write data.
REQ-009 m0_read_value_out, m1_read_value_out  output  32 each  read data to each master.
REQ-010 m0_ready_out, m1_ready_out  output  1 each  one-cycle completion pulse to each master.
REQ-011 address_out  output  32  address to the downstream memory.
REQ-012 sel_out  output  1  select to the downstream memory.
REQ-013 write_mask_out  output  4  write strobes to the downstream memory.
REQ-014 write_value_out  output  32  write data to the downstream memory.
REQ-015 read_value_in  input  32  read data from the downstream memory.
REQ-016 ready_in  input  1  ready from the downstream memory.
REQ-017 timeout_out  output  1  one-cycle pulse flagging an aborted transaction.

Function
REQ-018 FSM states SHALL be IDLE, GRANT0 and GRANT1, held in a registered state variable.
REQ-019 In IDLE, if any request is asserted the block SHALL go to the GRANT state of the winner on the next edge; if no request is asserted it SHALL stay in IDLE.
REQ-020 Winner selection: a single requester wins.
REQ-021 With both requesting and FAIR=1, the master not granted last SHALL win.
REQ-022 With both requesting and FAIR=0, m0 SHALL win.
REQ-023 last_grant SHALL update on entry to a GRANT state.
REQ-024 In GRANTx, sel_out SHALL be 1 and address_out, write_mask_out and write_value_out SHALL be the combinational pass-through of master x inputs.
REQ-025 In IDLE, sel_out, address_out, write_mask_out and write_value_out SHALL all be 0.
REQ-026 In GRANTx with ready_in=1, mx_ready_out SHALL be 1 in that same cycle.
REQ-027 In GRANTx with ready_in=1, mx_read_value_out SHALL equal read_value_in in that same cycle.
REQ-028 In GRANTx with ready_in=1, the FSM SHALL go to IDLE on the next edge, so sel_out drops for at least one cycle and a toggling downstream ready restarts from 0.
REQ-029 Read values SHALL be 0 except for the granted master in its ready cycle.
REQ-030 A non-granted master's ready_out SHALL be 0.
REQ-031 Latency: request at cycle N gives sel_out at N+1; with a memory asserting ready one cycle after sel, master ready occurs at N+2.
REQ-032 Back-to-back throughput SHALL be one transaction per 3 cycles per granted slot (IDLE, GRANT, ready).
REQ-033 A timeout counter SHALL clear on GRANT entry and increment each GRANT cycle with ready_in=0.
REQ-034 When TIMEOUT≠0 and the counter reaches TIMEOUT-1 with ready_in=0, in that cycle mx_ready_out SHALL be 1, mx_read_value_out SHALL be 0 and timeout_out SHALL be 1.
REQ-035 After a timeout abort the FSM SHALL go to IDLE on the next edge.
REQ-036 The timeout counter SHALL be $clog2(TIMEOUT+1) bits wide and SHALL saturate rather than wrap.
REQ-037 If the granted master drops its sel during GRANT (protocol violation), the block SHALL go to IDLE on the next edge with no ready to either master; sel_out stays 1 in that cycle.
REQ-038 A request arriving while the other master is granted SHALL wait and be evaluated in IDLE only.

Reset
REQ-039 On reset the state SHALL become IDLE, last_grant SHALL become 1 (so m0 wins the first tie) and the timeout counter SHALL become 0.
REQ-040 After reset, all outputs SHALL be 0.
REQ-041 Reset mid-transaction SHALL abandon the transaction without asserting any ready, and sel_out SHALL be 0 the cycle after the reset edge.
REQ-042 Reset SHALL take priority over all other transitions.

Verification
REQ-043 Single read: m0 reads 0x10, memory returns 0xDEADBEEF one cycle after sel -> m0_ready_out pulses at N+2 with 0xDEADBEEF; m1 outputs stay 0.
REQ-044 Tie, FAIR=1: both request continuously from reset -> grants go m0, m1, m0, m1, each separated by one IDLE cycle.
REQ-045 Tie, FAIR=0: both request continuously -> m0 is always granted and m1 never sees ready.
REQ-046 Timeout, TIMEOUT=4: ready_in held 0 -> ready and timeout_out pulse on the 4th GRANT cycle, read value 0, then IDLE.
REQ-047 Write: m1 writes mask 4'b0011 with value 0x0000ABCD -> write_mask_out and write_value_out match only while GRANT1, and are 0 otherwise.
REQ-048 Reset in GRANT0 before ready -> no ready pulse, sel_out is 0 the next cycle, and the next tie goes to m0.
